vmem_pipe_dpic: RTL

//  Pipelined, multi-outstanding vector memory model for VLSU/vector-unit benches.

---
 rtl/vmem_pipe_dpic_if.sv | 25 ++
 rtl/vmem_pipe_dpic.sv | 128 ++++++++++++
 2 files changed

// File: rtl/vmem_pipe_dpic_if.sv
// Request/response bus between a vector load/store unit and the pipelined memory model.
interface vmem_pipe_dpic_if #(
  parameter int VLEN = 1024
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [63:0]       req_paddr;
  logic [VLEN-1:0]   req_wdata;
  logic [VLEN/8-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [VLEN-1:0]   resp_rdata;
  logic              resp_is_store;

  modport master (
    output req_valid, req_wen, req_paddr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_is_store
  );

  modport slave (
    input  req_valid, req_wen, req_paddr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_is_store
  );
endinterface

// File: rtl/vmem_pipe_dpic.sv
// Pipelined in-order vector memory model: each accepted request touches the backing store at its
// accept edge, then its response waits in a DEPTH-entry ring until LATENCY has elapsed.
package vmem_pipe_dpic_pkg;
  // Sparse byte-addressed backing store; bytes never written read as zero.
  logic [7:0] mem [longint unsigned];

  function automatic logic [7:0] pmem_rd8(input longint unsigned addr);
    return mem.exists(addr) ? mem[addr] : 8'h00;
  endfunction

  function automatic void pmem_wr8(input longint unsigned addr, input logic [7:0] data);
    mem[addr] = data;
  endfunction
endpackage

module vmem_pipe_dpic #(
  parameter int VLEN    = 1024,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  vmem_pipe_dpic_if.slave  bus,
  output logic             busy
);
  import vmem_pipe_dpic_pkg::*;

  localparam int WORDS  = VLEN / 32;
  localparam int MWORDS = VLEN / 256;
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int NW     = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_INIT  = CW'(LATENCY - 1);
  localparam logic [NW-1:0] FULL      = NW'(DEPTH);

  typedef struct packed {
    logic          vld;
    logic          is_store;
    logic [CW-1:0] cnt;
  } ctrl_t;

  function automatic void pmem_read(input longint unsigned paddr, output int unsigned d [WORDS]);
    for (int k = 0; k < WORDS; k++) begin
      d[k] = '0;
      for (int b = 0; b < 4; b++) d[k][8*b +: 8] = pmem_rd8(paddr + 64'(4*k + b));
    end
  endfunction

  function automatic void pmem_write(input longint unsigned paddr, input int unsigned d [WORDS],
                                     input int unsigned m [MWORDS]);
    for (int i = 0; i < VLEN/8; i++)
      if (m[i/32][i%32]) pmem_wr8(paddr + 64'(i), d[i/4][8*(i%4) +: 8]);
  endfunction

  function automatic logic [VLEN-1:0] load_line(input logic [63:0] paddr);
    int unsigned     d [WORDS];
    logic [VLEN-1:0] line;
    line = '0;
    pmem_read(paddr, d);
    for (int k = 0; k < WORDS; k++) line[32*k +: 32] = d[k];
    return line;
  endfunction

  function automatic void store_line(input logic [63:0] paddr, input logic [VLEN-1:0] wdata,
                                     input logic [VLEN/8-1:0] wmask);
    int unsigned d [WORDS];
    int unsigned m [MWORDS];
    for (int k = 0; k < WORDS; k++)  d[k] = wdata[32*k +: 32];
    for (int k = 0; k < MWORDS; k++) m[k] = wmask[32*k +: 32];
    pmem_write(paddr, d, m);
  endfunction

  ctrl_t           ctrl_q  [DEPTH];
  logic [VLEN-1:0] rdata_q [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [NW-1:0]   count;
  ctrl_t           head;
  logic            fire, pop;

  assign head               = ctrl_q[rptr];
  assign bus.req_ready      = (count != FULL);
  assign bus.resp_valid     = head.vld && (head.cnt == '0);
  assign bus.resp_rdata     = bus.resp_valid ? rdata_q[rptr] : '0;
  assign bus.resp_is_store  = bus.resp_valid && head.is_store;
  assign busy               = (count != '0);
  assign fire               = bus.req_valid && bus.req_ready;
  assign pop                = bus.resp_valid && bus.resp_ready;

  // NOTE: rdata_q is left out of the reset branch; it is only observable through resp_valid,
  // which is cleared via vld, so resetting a wide payload array buys nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctrl_q[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (ctrl_q[i].vld && (ctrl_q[i].cnt != '0)) ctrl_q[i].cnt <= ctrl_q[i].cnt - 1'b1;

      if (pop) begin
        ctrl_q[rptr].vld <= 1'b0;
        rptr             <= (rptr == LAST_SLOT) ? '0 : rptr + 1'b1;
      end

      // NOTE: the backing store is updated by blocking calls at the accept edge, so memory
      // side effects follow acceptance order; all pipeline state still updates with <=.
      if (fire) begin
        if (bus.req_wen) begin
          store_line(bus.req_paddr, bus.req_wdata, bus.req_wmask);
          rdata_q[wptr] <= '0;
        end else begin
          rdata_q[wptr] <= load_line(bus.req_paddr);
        end
        ctrl_q[wptr] <= '{vld: 1'b1, is_store: bus.req_wen, cnt: CNT_INIT};
        wptr         <= (wptr == LAST_SLOT) ? '0 : wptr + 1'b1;
      end

      case ({fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule
